ex_mem_stage_reg: RTL and testbench
===================================

Name: ex_mem_stage_reg

Overview:
Parametrised EX/MEM pipeline stage register for the MIPS core. It replaces the fixed-width always-load EX/MEM register. It adds a valid/ready handshake, an optional one-entry skid buffer so backpressure is registered, a flush input for branch/exception squash, and control gating so bubbles never write memory or the register file. A saturating stall counter is exposed for performance debug.

Parameters:
DATA_W, 32, width of add_result, alu_result, rdata2 fields
REG_W, 5, width of the destination-register field
WB_W, 2, width of the WB control field
M_W, 3, width of the MEM control field
SKID, 1, 1 = one-entry skid buffer with registered in_ready; 0 = no skid, combinational in_ready
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  EX stage presents a valid instruction
in_ready  out  1  stage can accept this cycle
in_zero  in  1  ALU zero flag
in_wb_ctl  in  WB_W  WB control
in_m_ctl  in  M_W  MEM control
in_add_result  in  DATA_W  branch-target adder result
in_alu_result  in  DATA_W  ALU result
in_rdata2  in  DATA_W  store data (register read port 2)
in_dst  in  REG_W  destination register (RegDst mux output)
flush  in  1  squash all held and incoming entries
out_valid  out  1  MEM stage holds a valid instruction
out_ready  in  1  MEM stage consumes this cycle
zero, wb_ctlout, m_ctlout, add_result, alu_result, rdata2out, dst_out  out  matching widths  registered fields to MEM
stall_cnt  out  CNT_W  saturating count of cycles with out_valid && !out_ready

Behaviour:
- Reset is synchronous and active-high on clk. While reset is high at a rising edge: out_valid=0, skid_valid=0, every data field=0, stall_cnt=0. in_ready is 0 while reset is asserted. Reset mid-transfer drops all entries.
- Transfer rules: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- Latency: 1 cycle from in_fire to out_valid.
- Throughput: 1 instruction per cycle when out_ready stays high.
- Ctl gating: wb_ctlout and m_ctlout are forced to 0 whenever out_valid=0. Data fields hold their last loaded value when invalid.
- SKID=1 states (main = output register, skid = spare register):
  - EMPTY (main invalid): in_fire loads main -> FULL.
  - FULL: in_fire && out_fire loads main -> FULL. in_fire && !out_fire loads skid -> SKID. !in_fire && out_fire -> EMPTY. Otherwise hold.
  - SKID: in_ready=0. out_fire moves skid into main, skid_valid=0 -> FULL. Otherwise hold.
  - in_ready = !skid_valid && !reset. It is registered and has no combinational path from out_ready.
- SKID=0: no skid register. in_ready = !out_valid || out_ready, a combinational path from out_ready. States are EMPTY and FULL only.
- Flush:
  - Takes priority over all handshake events in the same cycle.
  - Next cycle: out_valid=0 and skid_valid=0.
  - An in_fire in the flush cycle is discarded.
  - A coincident out_fire still counts as consumed downstream; MEM is responsible for its own squash.
  - Data fields are not cleared.
  - stall_cnt is unaffected.
- stall_cnt: increments by 1 each cycle out_valid && !out_ready, saturates at 2^CNT_W-1, and clears only on reset.
- No X propagation: an invalid in_* field must never reach the outputs while out_valid=1.

Decomposition:
- Shared package (mips_pkg): default widths DATA_W/REG_W/WB_W/M_W, and a packed struct ex_mem_fields_t {zero, wb_ctl, m_ctl, add_result, alu_result, rdata2, dst} so the main and skid registers are single-vector assignments.
- One natural sub-module: pipe_skid_buf, a generic width-parametrised valid/ready skid buffer with flush. ex_mem_stage_reg instantiates it on the packed struct and adds ctl gating and stall_cnt.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid=1 -> out_valid=0, all outputs 0, stall_cnt=0, in_ready=0 during reset.
- Streaming: out_ready=1; drive alu_result 0x10, 0x20, 0x30 on consecutive cycles -> same values on alu_result one cycle later each, out_valid continuous, stall_cnt=0.
- Backpressure (SKID=1): load A=0xA, drop out_ready, present B=0xB -> B lands in skid, in_ready=0 next cycle. Raise out_ready -> outputs A then B, no loss or duplication, stall_cnt counts the held cycles exactly.
- Flush: FULL+SKID state with flush=1 and in_valid=1 (C=0xC) -> next cycle out_valid=0, wb_ctlout=0, m_ctlout=0, C never appears on the outputs.
- Bubble gating: in_m_ctl=3'b111, in_wb_ctl=2'b11, then in_valid=0 with out_ready=1 -> after the entry drains, m_ctlout=0 and wb_ctlout=0 while alu_result retains the last value.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default field widths, the EX/MEM payload
// layout, and the state encoding used by the valid/ready skid buffer.
package mips_pkg;

    localparam int unsigned MIPS_DATA_W = 32;
    localparam int unsigned MIPS_REG_W  = 5;
    localparam int unsigned MIPS_WB_W   = 2;
    localparam int unsigned MIPS_M_W    = 3;

    // EX/MEM payload at the default core widths
    typedef struct packed {
        logic                   zero;
        logic [MIPS_WB_W-1:0]   wb_ctl;
        logic [MIPS_M_W-1:0]    m_ctl;
        logic [MIPS_DATA_W-1:0] add_result;
        logic [MIPS_DATA_W-1:0] alu_result;
        logic [MIPS_DATA_W-1:0] rdata2;
        logic [MIPS_REG_W-1:0]  dst;
    } ex_mem_fields_t;

    // EMPTY: nothing held; FULL: output register valid; SKID: spare also valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with optional one-entry skid buffer
// and flush.
//   clk, reset       : clock, synchronous active-high reset
//   flush            : drop every held entry and any entry accepted this cycle
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload (registered)
// With SKID=1 in_ready comes from state only; with SKID=0 in_ready depends
// combinationally on out_ready.
module pipe_skid_buf
    import mips_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter bit          SKID = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t   state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         skid_valid;
    logic         in_fire;
    logic         out_fire;

    assign out_valid  = (state != ST_EMPTY);
    assign skid_valid = (state == ST_SKID);
    assign out_data   = main_q;

    generate
        if (SKID) begin : g_skid_ready
            assign in_ready = !skid_valid && !reset;
        end else begin : g_pass_ready
            assign in_ready = (!out_valid || out_ready) && !reset;
        end
    endgenerate

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // State and storage; flush only clears validity, payload stays put
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_data;
                        state  <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        // only reachable with SKID=1: in_ready is low otherwise
                        if (SKID) begin
                            skid_q <= in_data;
                            state  <= ST_SKID;
                        end
                    end else if (out_fire) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= ST_FULL;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline stage register with valid/ready handshake, optional skid
// buffer, flush, control gating for bubbles and a saturating stall counter.
//   clk, reset                   : clock, synchronous active-high reset
//   in_valid/in_ready            : EX-side handshake
//   in_zero .. in_dst            : EX results and control
//   flush                        : squash held and incoming entries
//   out_valid/out_ready          : MEM-side handshake
//   zero .. dst_out              : fields to MEM (ctl forced to 0 when invalid)
//   stall_cnt                    : cycles with out_valid && !out_ready, saturating
module ex_mem_stage_reg
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = MIPS_DATA_W,
    parameter int unsigned REG_W  = MIPS_REG_W,
    parameter int unsigned WB_W   = MIPS_WB_W,
    parameter int unsigned M_W    = MIPS_M_W,
    parameter bit          SKID   = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_zero,
    input  logic [WB_W-1:0]   in_wb_ctl,
    input  logic [M_W-1:0]    in_m_ctl,
    input  logic [DATA_W-1:0] in_add_result,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_rdata2,
    input  logic [REG_W-1:0]  in_dst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              zero,
    output logic [WB_W-1:0]   wb_ctlout,
    output logic [M_W-1:0]    m_ctlout,
    output logic [DATA_W-1:0] add_result,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] rdata2out,
    output logic [REG_W-1:0]  dst_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Payload at this instance's widths; same layout as ex_mem_fields_t
    typedef struct packed {
        logic              zero;
        logic [WB_W-1:0]   wb_ctl;
        logic [M_W-1:0]    m_ctl;
        logic [DATA_W-1:0] add_result;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] rdata2;
        logic [REG_W-1:0]  dst;
    } fields_t;

    localparam int unsigned FIELD_W = $bits(fields_t);

    fields_t in_fields;
    fields_t out_fields;

    always_comb begin
        in_fields            = '0;
        in_fields.zero       = in_zero;
        in_fields.wb_ctl     = in_wb_ctl;
        in_fields.m_ctl      = in_m_ctl;
        in_fields.add_result = in_add_result;
        in_fields.alu_result = in_alu_result;
        in_fields.rdata2     = in_rdata2;
        in_fields.dst        = in_dst;
    end

    pipe_skid_buf #(
        .W    (FIELD_W),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_fields),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_fields)
    );

    // Bubbles must never write memory or the register file
    assign wb_ctlout  = out_valid ? out_fields.wb_ctl : '0;
    assign m_ctlout   = out_valid ? out_fields.m_ctl  : '0;
    assign zero       = out_fields.zero;
    assign add_result = out_fields.add_result;
    assign alu_result = out_fields.alu_result;
    assign rdata2out  = out_fields.rdata2;
    assign dst_out    = out_fields.dst;

    // Backpressure counter; flush does not touch it
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
module tb_ex_mem_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_zero;
    logic [1:0]  in_wb_ctl;
    logic [2:0]  in_m_ctl;
    logic [31:0] in_add_result;
    logic [31:0] in_alu_result;
    logic [31:0] in_rdata2;
    logic [4:0]  in_dst;
    logic        flush;
    logic        out_ready;

    // dut a: SKID=1, CNT_W=16
    logic        a_in_ready, a_out_valid, a_zero;
    logic [1:0]  a_wb;
    logic [2:0]  a_m;
    logic [31:0] a_add, a_alu, a_rd2;
    logic [4:0]  a_dst;
    logic [15:0] a_stall;
    // dut b: SKID=0
    logic        b_in_ready, b_out_valid, b_zero;
    logic [1:0]  b_wb;
    logic [2:0]  b_m;
    logic [31:0] b_add, b_alu, b_rd2;
    logic [4:0]  b_dst;
    logic [15:0] b_stall;
    // dut c: SKID=1, CNT_W=4
    logic        c_in_ready, c_out_valid, c_zero;
    logic [1:0]  c_wb;
    logic [2:0]  c_m;
    logic [31:0] c_add, c_alu, c_rd2;
    logic [4:0]  c_dst;
    logic [3:0]  c_stall;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage_reg #(.SKID(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_zero(in_zero), .in_wb_ctl(in_wb_ctl), .in_m_ctl(in_m_ctl),
        .in_add_result(in_add_result), .in_alu_result(in_alu_result),
        .in_rdata2(in_rdata2), .in_dst(in_dst), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .zero(a_zero),
        .wb_ctlout(a_wb), .m_ctlout(a_m), .add_result(a_add), .alu_result(a_alu),
        .rdata2out(a_rd2), .dst_out(a_dst), .stall_cnt(a_stall)
    );

    ex_mem_stage_reg #(.SKID(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_zero(in_zero), .in_wb_ctl(in_wb_ctl), .in_m_ctl(in_m_ctl),
        .in_add_result(in_add_result), .in_alu_result(in_alu_result),
        .in_rdata2(in_rdata2), .in_dst(in_dst), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .zero(b_zero),
        .wb_ctlout(b_wb), .m_ctlout(b_m), .add_result(b_add), .alu_result(b_alu),
        .rdata2out(b_rd2), .dst_out(b_dst), .stall_cnt(b_stall)
    );

    ex_mem_stage_reg #(.SKID(1'b1), .CNT_W(4)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_zero(in_zero), .in_wb_ctl(in_wb_ctl), .in_m_ctl(in_m_ctl),
        .in_add_result(in_add_result), .in_alu_result(in_alu_result),
        .in_rdata2(in_rdata2), .in_dst(in_dst), .flush(flush),
        .out_valid(c_out_valid), .out_ready(out_ready), .zero(c_zero),
        .wb_ctlout(c_wb), .m_ctlout(c_m), .add_result(c_add), .alu_result(c_alu),
        .rdata2out(c_rd2), .dst_out(c_dst), .stall_cnt(c_stall)
    );

    // advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid      = 1'b0;
        in_zero       = 1'b0;
        in_wb_ctl     = 2'b00;
        in_m_ctl      = 3'b000;
        in_add_result = 32'h0;
        in_alu_result = 32'h0;
        in_rdata2     = 32'h0;
        in_dst        = 5'd0;
        flush         = 1'b0;
        out_ready     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset         = 1'b1;
        in_valid      = 1'b1;
        in_alu_result = 32'h55;
        in_m_ctl      = 3'b111;
        tick();
        tick();
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_alu !== 32'h0) begin failures++; $display("FAIL reset_alu got=%h exp=0", a_alu); end
        checks++; if ({a_zero, a_wb, a_m, a_add, a_rd2, a_dst} !== '0) begin failures++; $display("FAIL reset_fields got nonzero"); end
        checks++; if (a_stall !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", a_stall); end
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", a_in_ready); end
        checks++; if (b_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_noskid got=%b exp=0", b_in_ready); end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", a_in_ready); end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready     = 1'b1;
        in_valid      = 1'b1;
        in_zero       = 1'b1;
        in_wb_ctl     = 2'b10;
        in_m_ctl      = 3'b001;
        in_add_result = 32'h100;
        in_alu_result = 32'h10;
        in_rdata2     = 32'hDEAD;
        in_dst        = 5'd7;
        tick();
        checks++; if (a_out_valid !== 1'b1 || a_alu !== 32'h10) begin failures++; $display("FAIL stream_0 valid=%b alu=%h exp valid=1 alu=10", a_out_valid, a_alu); end
        checks++; if ({a_zero, a_wb, a_m, a_add, a_rd2, a_dst} !== {1'b1, 2'b10, 3'b001, 32'h100, 32'hDEAD, 5'd7}) begin
            failures++; $display("FAIL stream_fields zero=%b wb=%b m=%b add=%h rd2=%h dst=%0d", a_zero, a_wb, a_m, a_add, a_rd2, a_dst);
        end
        checks++; if (b_alu !== 32'h10) begin failures++; $display("FAIL stream_noskid_0 got=%h exp=10", b_alu); end
        in_alu_result = 32'h20;
        tick();
        checks++; if (a_out_valid !== 1'b1 || a_alu !== 32'h20) begin failures++; $display("FAIL stream_1 valid=%b alu=%h exp valid=1 alu=20", a_out_valid, a_alu); end
        in_alu_result = 32'h30;
        tick();
        checks++; if (a_out_valid !== 1'b1 || a_alu !== 32'h30) begin failures++; $display("FAIL stream_2 valid=%b alu=%h exp valid=1 alu=30", a_out_valid, a_alu); end
        checks++; if (b_out_valid !== 1'b1 || b_alu !== 32'h30) begin failures++; $display("FAIL stream_noskid_2 valid=%b alu=%h exp valid=1 alu=30", b_out_valid, b_alu); end
        in_valid = 1'b0;
        tick();
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", a_out_valid); end
        checks++; if (a_stall !== 16'd0) begin failures++; $display("FAIL stream_stall got=%0d exp=0", a_stall); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready     = 1'b1;
        in_valid      = 1'b1;
        in_alu_result = 32'hA;
        tick();
        out_ready     = 1'b0;
        in_alu_result = 32'hB;
        tick();
        checks++; if (a_alu !== 32'hA || a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_a alu=%h valid=%b exp alu=a valid=1", a_alu, a_out_valid); end
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", a_in_ready); end
        checks++; if (a_stall !== 16'd1) begin failures++; $display("FAIL bp_stall1 got=%0d exp=1", a_stall); end
        // offered but not accepted while skid is occupied
        in_alu_result = 32'hEE;
        tick();
        in_valid = 1'b0;
        checks++; if (a_alu !== 32'hA || a_stall !== 16'd2) begin failures++; $display("FAIL bp_hold2 alu=%h stall=%0d exp alu=a stall=2", a_alu, a_stall); end
        out_ready = 1'b1;
        tick();
        checks++; if (a_alu !== 32'hB || a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_b alu=%h valid=%b exp alu=b valid=1", a_alu, a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_back got=%b exp=1", a_in_ready); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", a_out_valid); end
        checks++; if (a_stall !== 16'd2) begin failures++; $display("FAIL bp_stall_final got=%0d exp=2", a_stall); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready     = 1'b1;
        in_valid      = 1'b1;
        in_alu_result = 32'h1;
        tick();
        out_ready     = 1'b0;
        in_alu_result = 32'h2;
        tick();
        flush         = 1'b1;
        in_alu_result = 32'hC;
        in_m_ctl      = 3'b111;
        in_wb_ctl     = 2'b11;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_wb !== 2'b00 || a_m !== 3'b000) begin
            failures++; $display("FAIL flush_skid valid=%b wb=%b m=%b exp 0/00/000", a_out_valid, a_wb, a_m);
        end
        checks++; if (a_alu !== 32'h1) begin failures++; $display("FAIL flush_data_kept got=%h exp=1", a_alu); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", a_in_ready); end
        out_ready = 1'b1;
        tick();
        checks++; if (a_out_valid !== 1'b0 || a_alu === 32'hC || a_alu === 32'h2) begin failures++; $display("FAIL flush_no_leak valid=%b alu=%h", a_out_valid, a_alu); end
        // flush coinciding with an accepted input while FULL
        in_m_ctl      = 3'b000;
        in_wb_ctl     = 2'b00;
        in_valid      = 1'b1;
        in_alu_result = 32'h3;
        tick();
        flush         = 1'b1;
        in_alu_result = 32'hC;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_alu !== 32'h3) begin failures++; $display("FAIL flush_infire valid=%b alu=%h exp valid=0 alu=3", a_out_valid, a_alu); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_infire_later got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_bubble_gating();
        do_reset();
        out_ready     = 1'b1;
        in_valid      = 1'b1;
        in_m_ctl      = 3'b111;
        in_wb_ctl     = 2'b11;
        in_alu_result = 32'h77;
        tick();
        checks++; if (a_m !== 3'b111 || a_wb !== 2'b11) begin failures++; $display("FAIL gate_valid m=%b wb=%b exp 111/11", a_m, a_wb); end
        in_valid = 1'b0;
        tick();
        checks++; if (a_out_valid !== 1'b0 || a_m !== 3'b000 || a_wb !== 2'b00) begin
            failures++; $display("FAIL gate_bubble valid=%b m=%b wb=%b exp 0/000/00", a_out_valid, a_m, a_wb);
        end
        checks++; if (a_alu !== 32'h77) begin failures++; $display("FAIL gate_alu_kept got=%h exp=77", a_alu); end
    endtask

    task automatic test_no_skid();
        do_reset();
        in_valid      = 1'b1;
        in_alu_result = 32'h41;
        tick();
        checks++; if (b_out_valid !== 1'b1 || b_alu !== 32'h41) begin failures++; $display("FAIL noskid_load valid=%b alu=%h exp 1/41", b_out_valid, b_alu); end
        checks++; if (b_in_ready !== 1'b0) begin failures++; $display("FAIL noskid_ready_low got=%b exp=0", b_in_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL noskid_ready_comb got=%b exp=1", b_in_ready); end
        in_alu_result = 32'h42;
        tick();
        checks++; if (b_alu !== 32'h42) begin failures++; $display("FAIL noskid_pass got=%h exp=42", b_alu); end
        out_ready     = 1'b0;
        in_alu_result = 32'h43;
        tick();
        in_valid = 1'b0;
        checks++; if (b_alu !== 32'h42 || b_out_valid !== 1'b1) begin failures++; $display("FAIL noskid_block alu=%h valid=%b exp 42/1", b_alu, b_out_valid); end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready     = 1'b1;
        in_valid      = 1'b1;
        in_alu_result = 32'h99;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (20) tick();
        checks++; if (c_stall !== 4'd15) begin failures++; $display("FAIL sat_cnt got=%0d exp=15", c_stall); end
        checks++; if (a_stall !== 16'd20) begin failures++; $display("FAIL sat_wide_cnt got=%0d exp=20", a_stall); end
        checks++; if (c_out_valid !== 1'b1 || c_alu !== 32'h99) begin failures++; $display("FAIL sat_hold valid=%b alu=%h exp 1/99", c_out_valid, c_alu); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble_gating();
        test_no_skid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
